// File: rtl/mem_ctrl_if.sv
// Request/response and byte-bus bundle around mem_ctrl. The controller takes the
// slave side; the master side is the fetch/LS requesters plus the RAM/IO model.
interface mem_ctrl_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_flush;
  logic        if_done;
  logic [31:0] if_data;

  logic        ls_req;
  logic        ls_r_nw;
  logic [2:0]  ls_type;
  logic [31:0] ls_addr;
  logic [31:0] ls_st_val;
  logic        ls_done;
  logic [31:0] ls_ld_val;

  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;

  modport master (
    output if_req, if_addr, if_flush,
    input  if_done, if_data,
    output ls_req, ls_r_nw, ls_type, ls_addr, ls_st_val,
    input  ls_done, ls_ld_val,
    output mem_din, io_buffer_full,
    input  mem_dout, mem_a, mem_wr
  );

  modport slave (
    input  if_req, if_addr, if_flush,
    output if_done, if_data,
    input  ls_req, ls_r_nw, ls_type, ls_addr, ls_st_val,
    output ls_done, ls_ld_val,
    input  mem_din, io_buffer_full,
    output mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates fetch vs load/store, walks 1/2/4 bytes
// over the 8-bit RAM/IO bus, and returns assembled, extended load data.
module mem_ctrl #(
  parameter int RD_LAT = 1,
  parameter int IO_MSB = 17
) (
  input  logic      clk_in,
  input  logic      rst_in,
  input  logic      rdy_in,
  mem_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  localparam logic [7:0] RD_LAT_B = 8'(RD_LAT);
  localparam logic [1:0] RD_LAT_I = 2'(RD_LAT);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [2:0]  nbytes_q, nbytes_d;
  logic        sext_q, sext_d;
  logic        fetch_q, fetch_d;
  logic [31:0] st_q, st_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] mem_a_q, mem_a_d;
  logic [7:0]  mem_dout_q, mem_dout_d;
  logic        mem_wr_q, mem_wr_d;
  logic        if_done_q, if_done_d;
  logic        ls_done_q, ls_done_d;
  logic [31:0] if_data_q, if_data_d;
  logic [31:0] ls_ld_val_q, ls_ld_val_d;

  logic        io_stall;
  logic [7:0]  last_byte;
  logic [7:0]  last_rd;
  logic [1:0]  cap_idx;
  logic [1:0]  wr_idx;
  logic [31:0] acc_cap;
  logic [31:0] ld_ext;

  // An IO write that finds the FIFO full is held on the same byte until it drains.
  assign io_stall  = (state_q == WR) && (mem_a_q[IO_MSB -: 2] == 2'b11) && bus.io_buffer_full;
  assign last_byte = {5'd0, nbytes_q} - 8'd1;
  assign last_rd   = {5'd0, nbytes_q} + RD_LAT_B - 8'd1;
  assign cap_idx   = cnt_q[1:0] - RD_LAT_I;
  assign wr_idx    = cnt_q[1:0] + 2'd1;

  // Accumulator with this cycle's returning byte merged in, so the final byte
  // can be folded straight into the result registered on entry to DONE.
  always_comb begin
    acc_cap = acc_q;
    if (cnt_q >= RD_LAT_B) begin
      acc_cap[{cap_idx, 3'b000} +: 8] = bus.mem_din;
    end
  end

  always_comb begin
    case (nbytes_q)
      3'd1:    ld_ext = sext_q ? {{24{acc_cap[7]}}, acc_cap[7:0]}
                               : {24'd0, acc_cap[7:0]};
      3'd2:    ld_ext = sext_q ? {{16{acc_cap[15]}}, acc_cap[15:0]}
                               : {16'd0, acc_cap[15:0]};
      default: ld_ext = acc_cap;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    nbytes_d    = nbytes_q;
    sext_d      = sext_q;
    fetch_d     = fetch_q;
    st_d        = st_q;
    acc_d       = acc_q;
    mem_a_d     = mem_a_q;
    mem_dout_d  = mem_dout_q;
    mem_wr_d    = mem_wr_q;
    if_done_d   = 1'b0;
    ls_done_d   = 1'b0;
    if_data_d   = if_data_q;
    ls_ld_val_d = ls_ld_val_q;

    case (state_q)
      IDLE: begin
        mem_wr_d = 1'b0;
        if (bus.ls_req) begin
          case (bus.ls_type[1:0])
            2'b01:   nbytes_d = 3'd2;
            2'b10:   nbytes_d = 3'd1;
            default: nbytes_d = 3'd4;
          endcase
          sext_d  = bus.ls_type[2];
          fetch_d = 1'b0;
          st_d    = bus.ls_st_val;
          cnt_d   = '0;
          acc_d   = '0;
          mem_a_d = bus.ls_addr;
          if (bus.ls_r_nw) begin
            state_d = RD;
          end else begin
            state_d    = WR;
            mem_dout_d = bus.ls_st_val[7:0];
            mem_wr_d   = 1'b1;
          end
        end else if (bus.if_req && !bus.if_flush) begin
          nbytes_d = 3'd4;
          sext_d   = 1'b0;
          fetch_d  = 1'b1;
          cnt_d    = '0;
          acc_d    = '0;
          mem_a_d  = bus.if_addr;
          state_d  = RD;
        end
      end

      RD: begin
        if (fetch_q && bus.if_flush) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          acc_d = acc_cap;
          cnt_d = cnt_q + 8'd1;
          if (cnt_q < last_byte) begin
            mem_a_d = mem_a_q + 32'd1;
          end
          if (cnt_q == last_rd) begin
            state_d = DONE;
            cnt_d   = '0;
            if (fetch_q) begin
              if_done_d = 1'b1;
              if_data_d = acc_cap;
            end else begin
              ls_done_d   = 1'b1;
              ls_ld_val_d = ld_ext;
            end
          end
        end
      end

      WR: begin
        if (!io_stall) begin
          if (cnt_q == last_byte) begin
            state_d     = DONE;
            cnt_d       = '0;
            mem_wr_d    = 1'b0;
            ls_done_d   = 1'b1;
            ls_ld_val_d = '0;
          end else begin
            cnt_d      = cnt_q + 8'd1;
            mem_a_d    = mem_a_q + 32'd1;
            mem_dout_d = st_q[{wr_idx, 3'b000} +: 8];
          end
        end
      end

      DONE: begin
        state_d  = IDLE;
        mem_wr_d = 1'b0;
      end

      default: begin
        state_d  = IDLE;
        mem_wr_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      nbytes_q    <= '0;
      sext_q      <= 1'b0;
      fetch_q     <= 1'b0;
      st_q        <= '0;
      acc_q       <= '0;
      mem_a_q     <= '0;
      mem_dout_q  <= '0;
      mem_wr_q    <= 1'b0;
      if_done_q   <= 1'b0;
      ls_done_q   <= 1'b0;
      if_data_q   <= '0;
      ls_ld_val_q <= '0;
    end else if (rdy_in) begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      nbytes_q    <= nbytes_d;
      sext_q      <= sext_d;
      fetch_q     <= fetch_d;
      st_q        <= st_d;
      acc_q       <= acc_d;
      mem_a_q     <= mem_a_d;
      mem_dout_q  <= mem_dout_d;
      mem_wr_q    <= mem_wr_d;
      if_done_q   <= if_done_d;
      ls_done_q   <= ls_done_d;
      if_data_q   <= if_data_d;
      ls_ld_val_q <= ls_ld_val_d;
    end
  end

  // A flush arriving while a fetch result sits in DONE still cancels the pulse.
  assign bus.if_done   = if_done_q & ~(fetch_q && (state_q == DONE) && bus.if_flush);
  assign bus.if_data   = if_data_q;
  assign bus.ls_done   = ls_done_q;
  assign bus.ls_ld_val = ls_ld_val_q;
  assign bus.mem_a     = mem_a_q;
  assign bus.mem_dout  = mem_dout_q;
  assign bus.mem_wr    = mem_wr_q & rdy_in & ~io_stall;
endmodule
